// File: rtl/systolic_feeder_if.sv
// Bus bundle between a matrix source and the systolic feeder.
// Load handshake: a row beat transfers on a rising edge where load_valid and
// load_ready are both high; the source holds load_row_a/load_row_b stable while
// load_valid is high, and load_ready never depends combinationally on load_valid.
// The stream side (feed_valid/a_out/b_out) has no back-pressure.
interface systolic_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic            load_valid;
    logic            load_ready;
    logic [N*DW-1:0] load_row_a;
    logic [N*DW-1:0] load_row_b;
    logic            start;
    logic            busy;
    logic            pe_clear;
    logic            feed_valid;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            done;
    logic [2:0]      state_dbg;

    modport master (
        output load_valid, load_row_a, load_row_b, start,
        input  load_ready, busy, pe_clear, feed_valid, a_out, b_out, done, state_dbg
    );

    modport slave (
        input  load_valid, load_row_a, load_row_b, start,
        output load_ready, busy, pe_clear, feed_valid, a_out, b_out, done, state_dbg
    );
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array.
// Buffers one A and one B matrix (a row per load beat), then on start clears
// the array, streams diagonally skewed A rows (west) and B columns (north),
// zero-fills for DRAIN_CYCLES and pulses done. All outputs are registered.
module systolic_feeder #(
    parameter int N            = 4,
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);

    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int BEATS = 2 * N - 1;
    localparam int CSPAN = BEATS + DRAIN_CYCLES;
    localparam int CW    = (CSPAN > 1) ? $clog2(CSPAN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_CLEAR  = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q;
    logic [KW-1:0]     row_q;
    logic [CW-1:0]     beat_q;
    logic [DW-1:0]     a_buf_q [N][N];
    logic [DW-1:0]     b_buf_q [N][N];

    logic              load_ready_q;
    logic              busy_q;
    logic              pe_clear_q;
    logic              feed_valid_q;
    logic [N*DW-1:0]   a_out_q;
    logic [N*DW-1:0]   b_out_q;
    logic              done_q;

    logic [CW-1:0]     next_t_d;
    logic [N*DW-1:0]   a_skew_d;
    logic [N*DW-1:0]   b_skew_d;

    // Index of the beat that will be presented after the coming edge.
    always_comb begin
        next_t_d = '0;
        if (state_q != S_CLEAR) begin
            next_t_d = beat_q + CW'(1);
        end
    end

    // Skewed edge operands for beat next_t_d: lane i of A carries A[i][t-i],
    // lane j of B carries B[t-j][j]; positions outside the matrix are zero.
    always_comb begin
        a_skew_d = '0;
        b_skew_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                if (int'(next_t_d) == i + c) begin
                    a_skew_d[i*DW +: DW] = a_buf_q[i][c];
                    b_skew_d[i*DW +: DW] = b_buf_q[c][i];
                end
            end
        end
    end

    // Control FSM, operand buffers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            beat_q       <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            pe_clear_q   <= 1'b0;
            feed_valid_q <= 1'b0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            done_q       <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_buf_q[r][c] <= '0;
                    b_buf_q[r][c] <= '0;
                end
            end
        end else begin
            pe_clear_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load_valid && load_ready_q) begin
                        for (int c = 0; c < N; c++) begin
                            a_buf_q[row_q][c] <= bus.load_row_a[c*DW +: DW];
                            b_buf_q[row_q][c] <= bus.load_row_b[c*DW +: DW];
                        end
                        if (row_q == KW'(N - 1)) begin
                            row_q        <= '0;
                            state_q      <= S_LOADED;
                            load_ready_q <= 1'b0;
                        end else begin
                            row_q <= row_q + KW'(1);
                        end
                    end
                end
                S_LOADED: begin
                    // load_valid is ignored here; only start matters.
                    if (bus.start) begin
                        state_q    <= S_CLEAR;
                        busy_q     <= 1'b1;
                        pe_clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q      <= S_RUN;
                    beat_q       <= '0;
                    feed_valid_q <= 1'b1;
                    a_out_q      <= a_skew_d;
                    b_out_q      <= b_skew_d;
                end
                S_RUN: begin
                    if (beat_q == CW'(BEATS - 1)) begin
                        beat_q  <= '0;
                        a_out_q <= '0;
                        b_out_q <= '0;
                        if (DRAIN_CYCLES > 0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q      <= S_DONE;
                            feed_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end else begin
                        beat_q  <= beat_q + CW'(1);
                        a_out_q <= a_skew_d;
                        b_out_q <= b_skew_d;
                    end
                end
                S_DRAIN: begin
                    if (beat_q == CW'(DRAIN_CYCLES - 1)) begin
                        beat_q       <= '0;
                        state_q      <= S_DONE;
                        feed_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        beat_q <= beat_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    row_q        <= '0;
                    beat_q       <= '0;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    feed_valid_q <= 1'b0;
                    a_out_q      <= '0;
                    b_out_q      <= '0;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.busy       = busy_q;
    assign bus.pe_clear   = pe_clear_q;
    assign bus.feed_valid = feed_valid_q;
    assign bus.a_out      = a_out_q;
    assign bus.b_out      = b_out_q;
    assign bus.done       = done_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a DRAIN_CYCLES=4 instance and a DRAIN_CYCLES=0
// instance run in lockstep on the same stimulus. Expected stream beats come
// from a matrix model and are checked by a negedge monitor.
module tb_systolic_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int DR = 4;
    localparam int W  = N * DW;
    localparam int NB = 2 * N - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DW(DW)) bus ();
    systolic_feeder_if #(.N(N), .DW(DW)) bus_z ();

    assign bus_z.load_valid = bus.load_valid;
    assign bus_z.load_row_a = bus.load_row_a;
    assign bus_z.load_row_b = bus.load_row_b;
    assign bus_z.start      = bus.start;

    systolic_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(DR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_feeder #(.N(N), .DW(DW), .DRAIN_CYCLES(0)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    // Matrix model and scoreboard
    logic [DW-1:0]    ma [N][N];
    logic [DW-1:0]    mb [N][N];
    logic [2*W-1:0]   exp_q[$];
    logic [2*W-1:0]   exp_z_q[$];
    logic [W-1:0]     cap_a [NB];
    logic [W-1:0]     cap_b [NB];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_extra(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got beat %0h, expected no beat", name, act);
    endtask

    // Build each edge lane as a padded sequence: lane i starts after i zeros,
    // A lanes carry row i of A, B lanes carry column i of B.
    task automatic push_expected();
        logic [DW-1:0]  la [N][NB];
        logic [DW-1:0]  lb [N][NB];
        logic [2*W-1:0] beat;
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < NB; t++) begin
                la[i][t] = '0;
                lb[i][t] = '0;
            end
            for (int k = 0; k < N; k++) begin
                la[i][i+k] = ma[i][k];
                lb[i][i+k] = mb[k][i];
            end
        end
        for (int t = 0; t < NB; t++) begin
            beat = '0;
            for (int i = 0; i < N; i++) begin
                beat[W + i*DW +: DW] = la[i][t];
                beat[i*DW +: DW]     = lb[i][t];
            end
            exp_q.push_back(beat);
            exp_z_q.push_back(beat);
        end
        for (int d = 0; d < DR; d++) exp_q.push_back('0);
    endtask

    // Monitor: every feed_valid beat must match the head of the queue;
    // outside the stream the edge buses must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.feed_valid) begin
                if (exp_q.size() == 0) fail_extra("main_beat_extra", {bus.a_out, bus.b_out});
                else chk("main_beat", {bus.a_out, bus.b_out}, exp_q.pop_front());
            end else begin
                chk("main_idle_data", {bus.a_out, bus.b_out}, 64'h0);
            end
            if (bus_z.feed_valid) begin
                if (exp_z_q.size() == 0) fail_extra("z_beat_extra", {bus_z.a_out, bus_z.b_out});
                else chk("z_beat", {bus_z.a_out, bus_z.b_out}, exp_z_q.pop_front());
            end else begin
                chk("z_idle_data", {bus_z.a_out, bus_z.b_out}, 64'h0);
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_load_ready"}, bus.load_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_pe_clear"}, bus.pe_clear, 0);
        chk({tag, "_feed_valid"}, bus.feed_valid, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_data"}, {bus.a_out, bus.b_out}, 64'h0);
        chk({tag, "_z_busy"}, bus_z.busy, 0);
        chk({tag, "_z_load_ready"}, bus_z.load_ready, 1);
    endtask

    task automatic randomize_model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = DW'($urandom_range(0, 255));
                mb[r][c] = DW'($urandom_range(0, 255));
            end
        end
    endtask

    // Load N rows; with bp set, random idle gaps carry junk data.
    task automatic load_rows(input bit bp);
        logic [W-1:0] ra, rb;
        for (int r = 0; r < N; r++) begin
            if (bp) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bus.load_valid = 1'b0;
                    bus.load_row_a = W'($urandom);
                    bus.load_row_b = W'($urandom);
                end
            end
            @(negedge clk);
            chk("load_ready_beat", bus.load_ready, 1);
            for (int c = 0; c < N; c++) begin
                ra[c*DW +: DW] = ma[r][c];
                rb[c*DW +: DW] = mb[r][c];
            end
            bus.load_valid = 1'b1;
            bus.load_row_a = ra;
            bus.load_row_b = rb;
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("load_ready_full", bus.load_ready, 0);
        chk("z_load_ready_full", bus_z.load_ready, 0);
    endtask

    // Issue start at the current negedge and observe a full job.
    task automatic run_job(input bit capture);
        int clr_cnt = 0, clr_at = -1;
        int d_cnt = 0, d_at = -1, zd_cnt = 0, zd_at = -1;
        push_expected();
        bus.start = 1'b1;
        for (int e = 1; e <= 2*N + DR + 3; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                bus.start      = 1'b0;
                bus.load_valid = 1'b0;
                chk("busy_after_start", bus.busy, 1);
            end
            if (bus.pe_clear) begin clr_cnt++; clr_at = e - 1; end
            if (bus.done) begin d_cnt++; d_at = e - 1; chk("busy_in_done", bus.busy, 1); end
            if (bus_z.done) begin zd_cnt++; zd_at = e - 1; end
            if (capture && e >= 2 && e - 2 < NB) begin
                cap_a[e-2] = bus.a_out;
                cap_b[e-2] = bus.b_out;
            end
        end
        chk("clear_cycles", clr_cnt, 1);
        chk("clear_edge", clr_at, 0);
        chk("done_pulses", d_cnt, 1);
        chk("done_latency", d_at, 2*N + DR);
        chk("z_done_pulses", zd_cnt, 1);
        chk("z_done_latency", zd_at, 2*N);
        chk("busy_after_done", bus.busy, 0);
        chk("ready_after_done", bus.load_ready, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("z_queue_drained", exp_z_q.size(), 0);
    endtask

    // A start pulse while nothing is loaded must leave the feeder idle.
    task automatic start_ignored(input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_busy"}, bus.busy, 0);
            chk({tag, "_pe_clear"}, bus.pe_clear, 0);
            chk({tag, "_z_busy"}, bus_z.busy, 0);
        end
    endtask

    // Start a job, then hit reset one cycle while beat t=2 is on the bus.
    task automatic run_abort();
        push_expected();
        bus.start = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) bus.start = 1'b0;
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_z_q.delete();
        check_idle("abort");
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 0);
            chk("abort_z_no_done", bus_z.done, 0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_row_a = '0;
        bus.load_row_b = '0;
        bus.start      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        start_ignored("idle_start");

        // Fixed pattern with spot checks on the skew.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = DW'(8'h10 * r + c);
                mb[r][c] = DW'(8'h40 + 8'h10 * r + c);
            end
        end
        load_rows(1'b0);
        run_job(1'b1);
        chk("t0_a", cap_a[0], 32'h00000000);
        chk("t0_b", cap_b[0], 32'h00000040);
        chk("t3_a", cap_a[3], 32'h30211203);
        chk("t3_b", cap_b[3], 32'h43526170);
        chk("t6_a", cap_a[6], 32'h33000000);
        chk("t6_b", cap_b[6], 32'h73000000);

        // Back-pressured load; a 5th beat offered together with start is dropped.
        randomize_model();
        load_rows(1'b1);
        bus.load_valid = 1'b1;
        bus.load_row_a = W'($urandom);
        bus.load_row_b = W'($urandom);
        chk("fifth_beat_ready", bus.load_ready, 0);
        run_job(1'b0);

        // Reset mid-RUN, then start without reload does nothing.
        randomize_model();
        load_rows(1'b1);
        run_abort();
        start_ignored("post_abort_start");

        // Back-to-back jobs with fresh data each time.
        for (int j = 0; j < 2; j++) begin
            randomize_model();
            load_rows(j[0]);
            run_job(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand feeder for the N x N output-stationary systolic array built from the 8-bit multiply-accumulate processing elements.
- Buffers one N x N matrix A and one N x N matrix B, loaded a row per beat.
- On start, it clears the array, then drives the west edge (A rows) and north edge (B columns) with diagonally skewed, zero-padded streams.
- It then holds zeros for a drain period and pulses done.

Parameters:
- N, 4, array dimension (rows of A, columns of B, lanes per edge); legal 2..8.
- DW, 8, operand width in bits.
- DRAIN_CYCLES, 4, zero-fill cycles after the last skewed beat, so results settle in the array.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  a row beat is offered on load_row_a/load_row_b.
- load_ready  output  1  feeder accepts a row beat this cycle.
- load_row_a  input  N*DW  row k of A; column c at bits [c*DW +: DW].
- load_row_b  input  N*DW  row k of B; column c at bits [c*DW +: DW].
- start  input  1  request to stream the loaded matrices.
- busy  output  1  high in CLEAR, RUN, DRAIN and DONE.
- pe_clear  output  1  clear strobe to the array's rst inputs.
- feed_valid  output  1  a_out/b_out carry a stream beat (RUN or DRAIN).
- a_out  output  N*DW  west-edge operands; lane i (bits [i*DW +: DW]) feeds array row i.
- b_out  output  N*DW  north-edge operands; lane j feeds array column j.
- done  output  1  one-cycle pulse when the stream completes.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, row counter=0, beat counter=0, both buffers zeroed.
- Reset values: load_ready=1, busy=0, pe_clear=0, feed_valid=0, a_out=0, b_out=0, done=0.
- Reset asserted in any state, including mid-RUN, aborts immediately; done is not pulsed.
- States: IDLE -> LOADED -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - load_ready=1.
  - A beat is accepted when load_valid & load_ready: both rows are written to buffer row k, then k increments.
  - On the N-th accepted beat (k=N-1), k returns to 0 and the state goes to LOADED.
  - start is ignored in IDLE.
- LOADED:
  - load_ready=0; load_valid is ignored.
  - start moves the state to CLEAR.
  - If start and load_valid are both high, start wins and no beat is accepted.
- CLEAR:
  - Lasts exactly 1 cycle.
  - pe_clear=1, feed_valid=0, a_out=b_out=0.
- RUN:
  - Lasts 2N-1 cycles; beat index t=0..2N-2.
  - feed_valid=1.
  - a_out lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_out lane j = B[t-j][j] if 0 <= t-j < N, else 0.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles.
  - feed_valid=1, a_out=b_out=0.
  - If DRAIN_CYCLES=0, DRAIN is skipped.
- DONE:
  - Lasts 1 cycle: done=1, feed_valid=0, busy=1.
  - Then IDLE.
- Latency: 
  - The start edge is edge E0. pe_clear is visible after E0.
  - Beat t=0 is visible after E0+1.
  - done is visible after E0+2N+DRAIN_CYCLES.
  - N=4 default: done after E0+12.
- Buffers are retained after DONE. A new start requires a full reload of N beats; there is no partial reload.
- start in CLEAR, RUN, DRAIN or DONE is ignored.
- No arithmetic is performed. Operand values pass bit-exact, width DW.
- Beat counter width is clog2(2N-1+DRAIN_CYCLES), min 1. It wraps to 0 on RUN->DRAIN and DRAIN->DONE transitions.

Test Plan:
- Reset/idle: hold rst 2 cycles, then release.
  - Required: load_ready=1, busy=0, all data outputs 0.
  - A start pulse then causes no state change; busy stays 0.
- Load + stream, N=4, A[i][c]=0x10*i+c, B[r][j]=0x40+0x10*r+j.
  - Load 4 beats, one per cycle, then start.
  - pe_clear=1 for 1 cycle, then 7 RUN beats.
  - At t=3: a_out lanes 0..3 = 0x03,0x12,0x21,0x30; b_out lanes 0..3 = 0x70,0x61,0x52,0x43.
  - At t=0: a_out lane0=0x00, lane1..3=0; b_out lane0=0x40, lane1..3=0.
  - At t=6: only lane3 of each is nonzero (A=0x33, B=0x73).
  - done is pulsed exactly 12 edges after the start edge.
- Load backpressure: toggle load_valid randomly; offer a 5th beat and start together.
  - Exactly 4 beats are written; the 5th is dropped (load_ready=0).
  - The stream uses the first 4 rows only.
- Reset mid-RUN: assert rst at t=2 for 1 cycle.
  - Next cycle: feed_valid=0, busy=0, outputs 0, no done pulse, load_ready=1.
  - A subsequent start without reload does nothing.
- Back-to-back jobs: after done, reload a second matrix set and start.
  - Second stream matches the new values with no stale data.
  - Exactly 1 cycle of pe_clear precedes it.
- DRAIN_CYCLES=0 build: after t=6, the DONE pulse follows immediately; no zero beats with feed_valid=1.
